// File: rtl/display_scan_decoder.sv
// Receive-side decoder for a multiplexed, active-low 4-digit 7-segment bus.
// Rebuilds the displayed characters and publishes one coherent snapshot per scan frame.
module display_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned FRAME_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] anx,
    input  logic [7:0] value,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dpMask,
    output logic       frameValid,
    output logic       segError,
    output logic       stale
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TmoW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(FRAME_TIMEOUT);

    localparam logic [3:0] CodeDash  = 4'hA;
    localparam logic [3:0] CodeBad   = 4'hE;
    localparam logic [3:0] CodeBlank = 4'hF;

    // Segment input is active-low; the table below is active-high gfedcba.
    function automatic logic [3:0] f_decode(input logic [6:0] seg_n);
        logic [6:0] seg;
        logic [3:0] code;
        seg = ~seg_n;
        case (seg)
            7'b0111111: code = 4'd0;
            7'b0000110: code = 4'd1;
            7'b1011011: code = 4'd2;
            7'b1001111: code = 4'd3;
            7'b1100110: code = 4'd4;
            7'b1101101: code = 4'd5;
            7'b1111101: code = 4'd6;
            7'b0000111: code = 4'd7;
            7'b1111111: code = 4'd8;
            7'b1101111: code = 4'd9;
            7'b1000000: code = CodeDash;
            7'b0000000: code = CodeBlank;
            default:    code = CodeBad;
        endcase
        f_decode = code;
    endfunction

    // Input stage and stability tracking
    logic [11:0]     r_sample;
    logic [CntW-1:0] r_stable_cnt;
    logic [CntW-1:0] w_stable_cnt_d;
    logic [11:0]     w_sample;
    logic            w_changed;
    logic            w_reach;

    assign w_sample  = {anx, value};
    assign w_changed = (w_sample != r_sample);

    always_comb begin
        w_stable_cnt_d = r_stable_cnt;
        if (w_changed) begin
            w_stable_cnt_d = CntW'(1);
        end else if (r_stable_cnt != CntMax) begin
            w_stable_cnt_d = r_stable_cnt + CntW'(1);
        end
    end

    // Fires only on the edge the count first arrives at the threshold, so long holds act once.
    assign w_reach = (w_stable_cnt_d == CntMax) && (w_changed || (r_stable_cnt != CntMax));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sample     <= '1;
            r_stable_cnt <= '0;
        end else begin
            r_sample     <= w_sample;
            r_stable_cnt <= w_stable_cnt_d;
        end
    end

    // Anode decode
    logic       w_sel_valid;
    logic [1:0] w_sel_idx;
    logic       w_illegal;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = 2'd0;
        w_illegal   = 1'b0;
        case (anx)
            4'b1110: begin w_sel_valid = 1'b1; w_sel_idx = 2'd0; end
            4'b1101: begin w_sel_valid = 1'b1; w_sel_idx = 2'd1; end
            4'b1011: begin w_sel_valid = 1'b1; w_sel_idx = 2'd2; end
            4'b0111: begin w_sel_valid = 1'b1; w_sel_idx = 2'd3; end
            4'b1111: ;
            default: w_illegal = 1'b1;
        endcase
    end

    // Capture into shadow registers
    logic [3:0]      w_glyph;
    logic            w_capture;
    logic            w_bad_glyph;
    logic            w_anx_error;
    logic            w_publish;
    logic [3:0]      r_seen_mask;
    logic [3:0]      w_seen_mask_d;
    logic [3:0][3:0] r_shadow;
    logic [3:0][3:0] w_shadow_d;
    logic [3:0]      r_shadow_dp;
    logic [3:0]      w_shadow_dp_d;

    assign w_glyph     = f_decode(value[6:0]);
    assign w_capture   = w_reach && w_sel_valid;
    assign w_bad_glyph = w_capture && (w_glyph == CodeBad);
    assign w_anx_error = w_reach && w_illegal;
    assign w_publish   = (r_seen_mask == 4'b1111);

    always_comb begin
        w_seen_mask_d = w_publish ? 4'b0000 : r_seen_mask;
        w_shadow_d    = r_shadow;
        w_shadow_dp_d = r_shadow_dp;
        if (w_capture) begin
            w_seen_mask_d[w_sel_idx] = 1'b1;
            w_shadow_d[w_sel_idx]    = w_glyph;
            w_shadow_dp_d[w_sel_idx] = ~value[7];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_seen_mask <= '0;
            r_shadow    <= {4{CodeBlank}};
            r_shadow_dp <= '0;
        end else begin
            r_seen_mask <= w_seen_mask_d;
            r_shadow    <= w_shadow_d;
            r_shadow_dp <= w_shadow_dp_d;
        end
    end

    // Published outputs and error pulse
    logic [3:0][3:0] r_digits;
    logic [3:0]      r_dp_mask;
    logic            r_frame_valid;
    logic            r_seg_error;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_digits      <= {4{CodeBlank}};
            r_dp_mask     <= '0;
            r_frame_valid <= 1'b0;
            r_seg_error   <= 1'b0;
        end else begin
            r_frame_valid <= w_publish;
            r_seg_error   <= w_bad_glyph || w_anx_error;
            if (w_publish) begin
                r_digits  <= r_shadow;
                r_dp_mask <= r_shadow_dp;
            end
        end
    end

    // Frame timeout; cleared on the publish edge so stale drops with frameValid
    logic [TmoW-1:0] r_tmo_cnt;
    logic [TmoW-1:0] w_tmo_cnt_d;

    always_comb begin
        w_tmo_cnt_d = r_tmo_cnt;
        if (w_publish) begin
            w_tmo_cnt_d = '0;
        end else if (r_tmo_cnt != TmoMax) begin
            w_tmo_cnt_d = r_tmo_cnt + TmoW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_d;
        end
    end

    assign digit0     = r_digits[0];
    assign digit1     = r_digits[1];
    assign digit2     = r_digits[2];
    assign digit3     = r_digits[3];
    assign dpMask     = r_dp_mask;
    assign frameValid = r_frame_valid;
    assign segError   = r_seg_error;
    assign stale      = (r_tmo_cnt == TmoMax);

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder: table-driven scan frames plus hand-written
// sequences for timeout, latency, glitch, illegal anode and mid-frame reset.
module tb_display_scan_decoder;

    localparam int unsigned StableCycles = 4;
    localparam int unsigned FrameTimeout = 16;

    logic       clk    = 1'b0;
    logic       resetN = 1'b1;
    logic [3:0] anx    = 4'hF;
    logic [7:0] value  = 8'hFF;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] dpMask;
    logic       frameValid;
    logic       segError;
    logic       stale;
    logic [15:0] digits_all;

    display_scan_decoder #(
        .STABLE_CYCLES(StableCycles),
        .FRAME_TIMEOUT(FrameTimeout)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .anx        (anx),
        .value      (value),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .dpMask     (dpMask),
        .frameValid (frameValid),
        .segError   (segError),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    assign digits_all = {digit3, digit2, digit1, digit0};

    // Cycles high, sampled on the falling edge; a 1-cycle pulse adds exactly one.
    int unsigned fv_count  = 0;
    int unsigned err_count = 0;

    always @(negedge clk) begin
        if (frameValid) fv_count <= fv_count + 1;
        if (segError) err_count <= err_count + 1;
    end

    typedef struct packed {
        logic [31:0] vals;        // {digit3, digit2, digit1, digit0} bus values
        logic [15:0] exp_digits;
        logic [3:0]  exp_dp;
        logic [7:0]  exp_err;
    } frame_vec_t;

    frame_vec_t  vecs [4];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned fv0, err0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns n falling edges later (n rising edges seen).
    task automatic hold(input logic [3:0] a, input logic [7:0] v, input int n);
        anx   = a;
        value = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [31:0] vals);
        hold(4'b0111, vals[31:24], 8);
        hold(4'b1011, vals[23:16], 8);
        hold(4'b1101, vals[15:8], 8);
        hold(4'b1110, vals[7:0], 8);
    endtask

    initial begin
        vecs[0] = '{vals: 32'hC0_92_FF_00, exp_digits: 16'h05F8, exp_dp: 4'b0001, exp_err: 8'd0};
        vecs[1] = '{vals: 32'hBF_82_F8_FE, exp_digits: 16'hA67E, exp_dp: 4'b0000, exp_err: 8'd1};
        vecs[2] = '{vals: 32'h10_7F_80_12, exp_digits: 16'h9F85, exp_dp: 4'b1101, exp_err: 8'd0};
        vecs[3] = '{vals: 32'hF9_A4_B0_99, exp_digits: 16'h1234, exp_dp: 4'b0000, exp_err: 8'd0};

        // Reset state
        #1 resetN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_digits", 32'(digits_all), 32'hFFFF);
        check("reset_dp", 32'(dpMask), 32'h0);
        check("reset_fv", 32'(frameValid), 32'h0);
        check("reset_err", 32'(segError), 32'h0);
        check("reset_stale", 32'(stale), 32'h0);
        resetN = 1'b1;

        // Timeout from reset release with idle bus
        repeat (15) @(negedge clk);
        check("stale_at_15", 32'(stale), 32'h0);
        @(negedge clk);
        check("stale_at_16", 32'(stale), 32'h1);
        repeat (4) @(negedge clk);
        check("stale_holds", 32'(stale), 32'h1);

        // First frame: capture latency and stale dropping with frameValid
        hold(4'b0111, 8'hF9, 8);
        hold(4'b1011, 8'hA4, 8);
        hold(4'b1101, 8'hB0, 8);
        anx   = 4'b1110;
        value = 8'h99;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("latency_no_fv_%0d", i), 32'(frameValid), 32'h0);
        end
        check("stale_before_publish", 32'(stale), 32'h1);
        @(negedge clk);
        check("publish_fv", 32'(frameValid), 32'h1);
        check("publish_stale_drop", 32'(stale), 32'h0);
        check("publish_digits", 32'(digits_all), 32'h1234);
        hold(4'b1110, 8'h99, 3);
        hold(4'b1111, 8'hFF, 2);

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            fv0  = fv_count;
            err0 = err_count;
            scan(vecs[i].vals);
            hold(4'b1111, 8'hFF, 2);
            check($sformatf("frame%0d_digits", i), 32'(digits_all), 32'(vecs[i].exp_digits));
            check($sformatf("frame%0d_dp", i), 32'(dpMask), 32'(vecs[i].exp_dp));
            check($sformatf("frame%0d_fv_count", i), fv_count - fv0, 32'd1);
            check($sformatf("frame%0d_err_count", i), err_count - err0, 32'(vecs[i].exp_err));
        end

        // Glitch: 3-cycle pattern on digit0 must not be captured
        fv0  = fv_count;
        err0 = err_count;
        hold(4'b0111, 8'h92, 8);
        hold(4'b1011, 8'h82, 8);
        hold(4'b1101, 8'hF8, 8);
        hold(4'b1110, 8'hC0, 3);
        hold(4'b1110, 8'h99, 8);
        hold(4'b1111, 8'hFF, 2);
        check("glitch_digits", 32'(digits_all), 32'h5674);
        check("glitch_fv_count", fv_count - fv0, 32'd1);
        check("glitch_err_count", err_count - err0, 32'd0);

        // Illegal anode pattern mid-frame: one error, no capture
        fv0  = fv_count;
        err0 = err_count;
        hold(4'b0111, 8'hF9, 8);
        hold(4'b1011, 8'hA4, 8);
        hold(4'b1100, 8'hC0, 6);
        check("illegal_err_count", err_count - err0, 32'd1);
        check("illegal_no_fv", fv_count - fv0, 32'd0);
        hold(4'b1101, 8'hB0, 8);
        hold(4'b1110, 8'h99, 8);
        hold(4'b1111, 8'hFF, 2);
        check("illegal_frame_fv", fv_count - fv0, 32'd1);
        check("illegal_frame_digits", 32'(digits_all), 32'h1234);

        // Reset after two captures discards the partial frame
        hold(4'b0111, 8'hF9, 8);
        hold(4'b1011, 8'hA4, 8);
        resetN = 1'b0;
        #1;
        check("midreset_digits", 32'(digits_all), 32'hFFFF);
        check("midreset_dp", 32'(dpMask), 32'h0);
        check("midreset_fv", 32'(frameValid), 32'h0);
        check("midreset_stale", 32'(stale), 32'h0);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        fv0    = fv_count;
        hold(4'b1101, 8'hB0, 8);
        hold(4'b1110, 8'h99, 8);
        hold(4'b1111, 8'hFF, 2);
        check("midreset_partial_no_fv", fv_count - fv0, 32'd0);
        check("midreset_partial_digits", 32'(digits_all), 32'hFFFF);
        hold(4'b0111, 8'h92, 8);
        hold(4'b1011, 8'h82, 8);
        hold(4'b1111, 8'hFF, 2);
        check("midreset_frame_fv", fv_count - fv0, 32'd1);
        check("midreset_frame_digits", 32'(digits_all), 32'h5634);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
